// File: rtl/music_note_sequencer.sv
// music_note_sequencer
// Steps through a 16-step note pattern, advancing one step every FRAMES_PER_STEP
// frames, and presents a note half-period, a decaying envelope and a gate flag
// to the downstream per-line square-wave oscillator.
//
// Ports:
//   clk            pixel clock
//   reset          asynchronous, active-high reset
//   frame_tick     one-cycle pulse per frame
//   enable         play when high, pause when low
//   restart        one-cycle synchronous rewind to step 0 (IDLE)
//   pattern_select pattern ROM 0/1, sampled only when a step is loaded
//   note_period    half-period in scanlines, 0 = rest
//   envelope       current envelope level
//   gate           high while a note is sounding
//   step_index     step currently presented
//   part           toggles on every 15->0 pattern wrap
module music_note_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned DECAY_STEP      = 8,
    parameter int unsigned ENV_MAX         = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       restart,
    input  logic       pattern_select,
    output logic [7:0] note_period,
    output logic [4:0] envelope,
    output logic       gate,
    output logic [3:0] step_index,
    output logic       part
);

    localparam int unsigned NOTE_W = 8;
    localparam int unsigned ENV_W  = 5;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]        r_state;
    logic [NOTE_W-1:0] r_note;
    logic [ENV_W-1:0]  r_env;
    logic              r_gate;
    logic [STEP_W-1:0] r_step;
    logic              r_part;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic [1:0]        w_state_nxt;
    logic [NOTE_W-1:0] w_note_nxt;
    logic [ENV_W-1:0]  w_env_nxt;
    logic              w_gate_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_part_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [ENV_W:0]    w_env_diff;
    logic [ENV_W-1:0]  w_env_dec;
    logic [STEP_W-1:0] w_step_inc;
    logic [NOTE_W-1:0] w_load_note;

    // Pattern ROMs: 16 notes each, 0 = rest
    function automatic logic [NOTE_W-1:0] f_rom(input logic sel, input logic [STEP_W-1:0] idx);
        logic [NOTE_W-1:0] v;
        v = 8'd0;
        if (!sel) begin
            case (idx)
                4'd0:  v = 8'd25;  4'd1:  v = 8'd0;   4'd2:  v = 8'd25;  4'd3:  v = 8'd25;
                4'd4:  v = 8'd24;  4'd5:  v = 8'd0;   4'd6:  v = 8'd25;  4'd7:  v = 8'd28;
                4'd8:  v = 8'd25;  4'd9:  v = 8'd25;  4'd10: v = 8'd25;  4'd11: v = 8'd25;
                4'd12: v = 8'd24;  4'd13: v = 8'd0;   4'd14: v = 8'd25;  default: v = 8'd28;
            endcase
        end else begin
            case (idx)
                4'd0:  v = 8'd30;  4'd1:  v = 8'd0;   4'd2:  v = 8'd30;  4'd3:  v = 8'd27;
                4'd4:  v = 8'd24;  4'd5:  v = 8'd0;   4'd6:  v = 8'd24;  4'd7:  v = 8'd27;
                4'd8:  v = 8'd30;  4'd9:  v = 8'd30;  4'd10: v = 8'd27;  4'd11: v = 8'd27;
                4'd12: v = 8'd24;  4'd13: v = 8'd0;   4'd14: v = 8'd0;   default: v = 8'd0;
            endcase
        end
        return v;
    endfunction

    // Saturating decay: the borrow bit of the 6-bit difference flags underflow
    assign w_env_diff = {1'b0, r_env} - (ENV_W + 1)'(DECAY_STEP);
    assign w_env_dec  = w_env_diff[ENV_W] ? '0 : w_env_diff[ENV_W-1:0];
    assign w_step_inc = r_step + 4'd1;

    // Note for a step load: step 0 from IDLE, otherwise the following step
    assign w_load_note = f_rom(pattern_select, (r_state == S_IDLE) ? 4'd0 : w_step_inc);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_env_nxt   = r_env;
        w_step_nxt  = r_step;
        w_part_nxt  = r_part;
        w_cnt_nxt   = r_frame_cnt;
        w_gate_nxt  = 1'b0;

        if (restart) begin
            w_state_nxt = S_IDLE;
            w_note_nxt  = '0;
            w_env_nxt   = '0;
            w_step_nxt  = '0;
            w_part_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && enable) begin
                        w_state_nxt = S_PLAY;
                        w_note_nxt  = w_load_note;
                        w_env_nxt   = (w_load_note != 8'd0) ? ENV_W'(ENV_MAX) : '0;
                        w_step_nxt  = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PLAY: begin
                    if (!enable) begin
                        w_state_nxt = S_PAUSE;
                    end else if (frame_tick) begin
                        if (r_frame_cnt < CNT_W'(FRAMES_PER_STEP - 1)) begin
                            w_cnt_nxt = r_frame_cnt + 4'd1;
                            w_env_nxt = w_env_dec;
                        end else begin
                            w_cnt_nxt  = '0;
                            w_step_nxt = w_step_inc;
                            w_part_nxt = (r_step == 4'd15) ? ~r_part : r_part;
                            w_note_nxt = w_load_note;
                            w_env_nxt  = (w_load_note != 8'd0) ? ENV_W'(ENV_MAX) : '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (enable) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Gate reflects the values being registered this cycle
        w_gate_nxt = (w_state_nxt == S_PLAY) && enable && !restart &&
                     (w_note_nxt != 8'd0) && (w_env_nxt != 5'd0);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_note      <= '0;
            r_env       <= '0;
            r_gate      <= 1'b0;
            r_step      <= '0;
            r_part      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_note      <= w_note_nxt;
            r_env       <= w_env_nxt;
            r_gate      <= w_gate_nxt;
            r_step      <= w_step_nxt;
            r_part      <= w_part_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    assign note_period = r_note;
    assign envelope    = r_env;
    assign gate        = r_gate;
    assign step_index  = r_step;
    assign part        = r_part;

endmodule

// File: tb/tb_music_note_sequencer.sv
// tb_music_note_sequencer
// Directed bench for music_note_sequencer. Instance a uses the default
// parameters; instance b shares the stimulus with DECAY_STEP=12 to exercise
// envelope saturation.
module tb_music_note_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, frame_tick, enable, restart, pattern_select;
    logic [7:0] note_a, note_b;
    logic [4:0] env_a, env_b;
    logic       gate_a, gate_b;
    logic [3:0] step_a, step_b;
    logic       part_a, part_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom0 [0:15] = '{8'd25, 8'd0, 8'd25, 8'd25, 8'd24, 8'd0, 8'd25, 8'd28,
                                8'd25, 8'd25, 8'd25, 8'd25, 8'd24, 8'd0, 8'd25, 8'd28};

    music_note_sequencer #(.FRAMES_PER_STEP(4), .DECAY_STEP(8), .ENV_MAX(31)) u_dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .restart(restart), .pattern_select(pattern_select),
        .note_period(note_a), .envelope(env_a), .gate(gate_a),
        .step_index(step_a), .part(part_a)
    );

    music_note_sequencer #(.FRAMES_PER_STEP(4), .DECAY_STEP(12), .ENV_MAX(31)) u_dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .restart(restart), .pattern_select(pattern_select),
        .note_period(note_b), .envelope(env_b), .gate(gate_b),
        .step_index(step_b), .part(part_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick every 20 cycles; returns on the negedge after the tick edge
    task automatic tick();
        repeat (19) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; restart = 1'b0; pattern_select = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_note", 32'(note_a), 32'd0);
        chk("rst_env",  32'(env_a),  32'd0);
        chk("rst_gate", 32'(gate_a), 32'd0);
        chk("rst_step", 32'(step_a), 32'd0);
        chk("rst_part", 32'(part_a), 32'd0);
        chk("rst_b",    32'({note_b, env_b, gate_b, step_b, part_b}), 32'd0);
        reset = 1'b0;

        // First step of pattern 0 and envelope decay
        tick();
        chk("t1_note", 32'(note_a), 32'd25);
        chk("t1_env",  32'(env_a),  32'd31);
        chk("t1_gate", 32'(gate_a), 32'd1);
        chk("t1_step", 32'(step_a), 32'd0);
        chk("t1_env_b", 32'(env_b), 32'd31);
        tick();
        chk("t2_env",   32'(env_a), 32'd23);
        chk("t2_env_b", 32'(env_b), 32'd19);
        tick();
        chk("t3_env",    32'(env_a),  32'd15);
        chk("t3_env_b",  32'(env_b),  32'd7);
        chk("t3_gate_b", 32'(gate_b), 32'd1);
        tick();
        chk("t4_env",    32'(env_a),  32'd7);
        chk("t4_gate",   32'(gate_a), 32'd1);
        chk("t4_env_b",  32'(env_b),  32'd0);
        chk("t4_gate_b", 32'(gate_b), 32'd0);
        tick();
        chk("t5_step", 32'(step_a), 32'd1);
        chk("t5_note", 32'(note_a), 32'd0);
        chk("t5_env",  32'(env_a),  32'd0);
        chk("t5_gate", 32'(gate_a), 32'd0);
        chk("t5_step_b", 32'(step_b), 32'd1);
        chk("t5_note_b", 32'(note_b), 32'd0);
        ticks(3);

        // Remaining steps follow ROM 0
        for (int s = 2; s < 16; s++) begin
            tick();
            chk("seq_step", 32'(step_a), 32'(s));
            chk("seq_note", 32'(note_a), 32'(rom0[s]));
            chk("seq_gate", 32'(gate_a), (rom0[s] != 8'd0) ? 32'd1 : 32'd0);
            ticks(3);
        end

        // Tick 65 wraps, tick 129 wraps again
        tick();
        chk("wrap1_step", 32'(step_a), 32'd0);
        chk("wrap1_part", 32'(part_a), 32'd1);
        chk("wrap1_note", 32'(note_a), 32'd25);
        chk("wrap1_part_b", 32'(part_b), 32'd1);
        ticks(63);
        chk("t128_step", 32'(step_a), 32'd15);
        chk("t128_part", 32'(part_a), 32'd1);
        tick();
        chk("wrap2_step", 32'(step_a), 32'd0);
        chk("wrap2_part", 32'(part_a), 32'd0);

        // Pause after the second tick of step 3
        ticks(13);
        chk("p_pre_step", 32'(step_a), 32'd3);
        chk("p_pre_env",  32'(env_a),  32'd23);
        enable = 1'b0;
        @(negedge clk);
        chk("p_gate", 32'(gate_a), 32'd0);
        chk("p_env",  32'(env_a),  32'd23);
        chk("p_step", 32'(step_a), 32'd3);
        chk("p_note", 32'(note_a), 32'd25);
        ticks(5);
        chk("p_hold_env",  32'(env_a),  32'd23);
        chk("p_hold_step", 32'(step_a), 32'd3);
        chk("p_hold_gate", 32'(gate_a), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("p_resume_gate", 32'(gate_a), 32'd1);
        tick();
        chk("p_resume_env",  32'(env_a),  32'd15);
        chk("p_resume_step", 32'(step_a), 32'd3);
        tick();
        chk("p_f3_env", 32'(env_a), 32'd7);
        tick();
        chk("p_s4_step", 32'(step_a), 32'd4);
        chk("p_s4_note", 32'(note_a), 32'd24);
        chk("p_s4_env",  32'(env_a),  32'd31);

        // Restart coinciding with a tick during step 7
        ticks(11);
        tick();
        chk("r_pre_step", 32'(step_a), 32'd7);
        chk("r_pre_note", 32'(note_a), 32'd28);
        repeat (19) @(negedge clk);
        frame_tick = 1'b1; restart = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; restart = 1'b0;
        chk("r_note", 32'(note_a), 32'd0);
        chk("r_env",  32'(env_a),  32'd0);
        chk("r_gate", 32'(gate_a), 32'd0);
        chk("r_step", 32'(step_a), 32'd0);
        chk("r_part", 32'(part_a), 32'd0);
        tick();
        chk("r_t1_step", 32'(step_a), 32'd0);
        chk("r_t1_note", 32'(note_a), 32'd25);
        chk("r_t1_env",  32'(env_a),  32'd31);
        chk("r_t1_gate", 32'(gate_a), 32'd1);

        // pattern_select change mid step 2 takes effect at step 3
        ticks(7);
        tick();
        chk("ps_s2_note", 32'(note_a), 32'd25);
        pattern_select = 1'b1;
        tick();
        chk("ps_mid_note", 32'(note_a), 32'd25);
        chk("ps_mid_step", 32'(step_a), 32'd2);
        ticks(2);
        chk("ps_end_note", 32'(note_a), 32'd25);
        tick();
        chk("ps_s3_step", 32'(step_a), 32'd3);
        chk("ps_s3_note", 32'(note_a), 32'd27);
        chk("ps_s3_env",  32'(env_a),  32'd31);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_note", 32'(note_a), 32'd0);
        chk("ar_env",  32'(env_a),  32'd0);
        chk("ar_gate", 32'(gate_a), 32'd0);
        chk("ar_step", 32'(step_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores ticks while disabled, then loads step 0 of pattern 1
        enable = 1'b0;
        tick();
        chk("idle_dis_note", 32'(note_a), 32'd0);
        chk("idle_dis_gate", 32'(gate_a), 32'd0);
        enable = 1'b1;
        tick();
        chk("idle_en_note", 32'(note_a), 32'd30);
        chk("idle_en_env",  32'(env_a),  32'd31);
        chk("idle_en_gate", 32'(gate_a), 32'd1);
        chk("idle_en_step", 32'(step_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
